control_sequencer: RTL and testbench

Hardwired control unit that drives the datapath through fetch and execute of three-register ALU instructions and two-register MUL/DIV, replacing hand-sequenced control stimulus. It sits beside `datapath`, reads the IR contents, and emits the register-select, bus-source, load-enable and ALU-operation signals step by step (T0..T7). Outputs are registered (Moore), so every control line is stable for a whole clock cycle and takes effect at the following rising edge.

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/control_sequencer_reg_select_decoder.sv | 19 +
 rtl/control_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: the step-state
// enum, opcode constants, IR field positions, the bundle of single-bit
// control lines, and opcode classification helpers.
package cpu_ctrl_pkg;

  // Fetch steps T0..T3, execute steps T4..T7, and an idle state.
  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7
  } state_e;

  // Opcodes 00000..OP_ALU_LAST are three-register ALU operations whose
  // opcode is also the ALU function code.
  localparam logic [4:0] OP_ALU_LAST = 5'b01011;
  localparam logic [4:0] OP_MUL      = 5'b01111;
  localparam logic [4:0] OP_DIV      = 5'b10000;
  localparam logic [4:0] OP_NOP      = 5'b11010;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  // IR field bit positions.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Single-bit bus-source and load-enable lines, registered as one bundle.
  typedef struct packed {
    logic pcOut;
    logic zLowOut;
    logic zHighOut;
    logic mdrOut;
    logic marIn;
    logic mdrIn;
    logic irIn;
    logic pcIn;
    logic yIn;
    logic zIn;
    logic loIn;
    logic hiIn;
    logic incPc;
    logic read;
  } ctrl_t;

  function automatic logic is_alu_class(input logic [4:0] opcode);
    return opcode <= OP_ALU_LAST;
  endfunction

  function automatic logic is_mul_div(input logic [4:0] opcode);
    return (opcode == OP_MUL) || (opcode == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [4:0] opcode);
    return is_alu_class(opcode) || is_mul_div(opcode) ||
           (opcode == OP_NOP) || (opcode == OP_HALT);
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// Register-select decoder: turns a 4-bit register index into a 16-bit
// one-hot select, all zeros when not enabled.
//   index_i   register number 0..15
//   enable_i  assert the selected bit
//   onehot_o  bit n set selects register Rn
module reg_select_decoder (
  input  logic [3:0]  index_i,
  input  logic        enable_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (enable_i) begin
      onehot_o[index_i] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps the datapath through instruction
// fetch (T0..T3) and execute (T4..T7) for ALU, MUL/DIV, NOP and HALT.
// All control outputs are registered, computed from the next state, so each
// line is glitch-free for the whole cycle of its step.
//   Clock, Resetn        clock; synchronous active-low reset
//   Run                  permits starting a new instruction
//   IR                   instruction register contents
//   Mem_ready            memory read data valid
//   PCout..MDRout, Rout  bus sources (at most one active per cycle)
//   Rin, MARin..HIin     load enables
//   IncPC, Read          PC increment request; memory read strobe
//   operation            ALU function code, held outside T5
//   Halted, Illegal      sticky halt flag; one-cycle illegal-opcode pulse
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RUN_START_PC = 32'd0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        PCin,
  output logic        Yin,
  output logic        Zin,
  output logic        LOin,
  output logic        HIin,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  operation,
  output logic        Halted,
  output logic        Illegal
);

  state_e      state_q, state_d;
  ctrl_t       ctl_q, ctl_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] rout_q, rout_d;
  logic [15:0] rin_q, rin_d;
  logic [3:0]  routIdx_d, rinIdx_d;
  logic        routEn_d, rinEn_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        isMulDiv;
  logic        unusedBits;

  assign opcode   = IR[OPC_MSB:OPC_LSB];
  assign ra       = IR[RA_MSB:RA_LSB];
  assign rb       = IR[RB_MSB:RB_LSB];
  assign rc       = IR[RC_MSB:RC_LSB];
  assign isMulDiv = is_mul_div(opcode);

  // The low IR bits carry no control information and the start PC is
  // owned by the datapath.
  assign unusedBits = ^{IR[RC_LSB-1:0], RUN_START_PC};

  // Step sequencing. NOP, HALT and illegal opcodes finish after the IR load
  // step; a finished instruction chains straight into the next fetch while
  // Run is high. Run is only looked at on instruction boundaries, so dropping
  // it mid-instruction never cuts the instruction short.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: if (Run && !halted_q) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   if (Mem_ready) state_d = S_T3;
      S_T3: begin
        if (is_alu_class(opcode) || isMulDiv) begin
          state_d = S_T4;
        end else if (opcode == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          illegal_d = !is_legal(opcode);
          state_d   = Run ? S_T0 : S_IDLE;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = isMulDiv ? S_T7 : (Run ? S_T0 : S_IDLE);
      S_T7:   state_d = Run ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control lines for the step being entered. MUL/DIV read Ra then Rb into
  // the ALU, while ALU-class instructions read Rb then Rc and write Ra.
  always_comb begin
    ctl_d     = '0;
    routEn_d  = 1'b0;
    routIdx_d = '0;
    rinEn_d   = 1'b0;
    rinIdx_d  = '0;
    op_d      = op_q;
    case (state_d)
      S_T0: begin
        ctl_d.pcOut = 1'b1;
        ctl_d.marIn = 1'b1;
        ctl_d.incPc = 1'b1;
        ctl_d.zIn   = 1'b1;
      end
      S_T1: begin
        ctl_d.zLowOut = 1'b1;
        ctl_d.pcIn    = 1'b1;
      end
      S_T2: begin
        ctl_d.read  = 1'b1;
        ctl_d.mdrIn = 1'b1;
      end
      S_T3: begin
        ctl_d.mdrOut = 1'b1;
        ctl_d.irIn   = 1'b1;
      end
      S_T4: begin
        ctl_d.yIn = 1'b1;
        routEn_d  = 1'b1;
        routIdx_d = isMulDiv ? ra : rb;
      end
      S_T5: begin
        ctl_d.zIn = 1'b1;
        routEn_d  = 1'b1;
        routIdx_d = isMulDiv ? rb : rc;
        op_d      = opcode;
      end
      S_T6: begin
        ctl_d.zLowOut = 1'b1;
        if (isMulDiv) begin
          ctl_d.loIn = 1'b1;
        end else begin
          rinEn_d  = 1'b1;
          rinIdx_d = ra;
        end
      end
      S_T7: begin
        ctl_d.zHighOut = 1'b1;
        ctl_d.hiIn     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decoder uRoutDecoder (
    .index_i  (routIdx_d),
    .enable_i (routEn_d),
    .onehot_o (rout_d)
  );

  reg_select_decoder uRinDecoder (
    .index_i  (rinIdx_d),
    .enable_i (rinEn_d),
    .onehot_o (rin_d)
  );

  // State and every output register; reset clears all of them from any step.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      ctl_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
      rout_q    <= '0;
      rin_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      op_q      <= op_d;
      rout_q    <= rout_d;
      rin_q     <= rin_d;
    end
  end

  assign PCout     = ctl_q.pcOut;
  assign Zlowout   = ctl_q.zLowOut;
  assign ZHighout  = ctl_q.zHighOut;
  assign MDRout    = ctl_q.mdrOut;
  assign MARin     = ctl_q.marIn;
  assign MDRin     = ctl_q.mdrIn;
  assign IRin      = ctl_q.irIn;
  assign PCin      = ctl_q.pcIn;
  assign Yin       = ctl_q.yIn;
  assign Zin       = ctl_q.zIn;
  assign LOin      = ctl_q.loIn;
  assign HIin      = ctl_q.hiIn;
  assign IncPC     = ctl_q.incPc;
  assign Read      = ctl_q.read;
  assign Rout      = rout_q;
  assign Rin       = rin_q;
  assign operation = op_q;
  assign Halted    = halted_q;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks ALU, MUL, memory-wait,
// illegal, NOP, HALT and mid-instruction reset scenarios, checking every
// output each cycle against hand-computed step values, plus the
// single-bus-source rule on every cycle.
module tb_control_sequencer;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        PCout, Zlowout, ZHighout, MDRout;
  logic [15:0] Rout, Rin;
  logic        MARin, MDRin, IRin, PCin, Yin, Zin, LOin, HIin;
  logic        IncPC, Read;
  logic [4:0]  operation;
  logic        Halted, Illegal;

  int errors;
  int checks;
  int cycleNum;
  bit busCheckOn;

  // Bit masks in the order {PCout,Zlowout,ZHighout,MDRout,MARin,MDRin,
  // IRin,PCin,Yin,Zin,LOin,HIin,IncPC,Read}.
  localparam logic [13:0] PCOUT    = 14'h2000;
  localparam logic [13:0] ZLOWOUT  = 14'h1000;
  localparam logic [13:0] ZHIGHOUT = 14'h0800;
  localparam logic [13:0] MDROUT   = 14'h0400;
  localparam logic [13:0] MARIN    = 14'h0200;
  localparam logic [13:0] MDRIN    = 14'h0100;
  localparam logic [13:0] IRIN     = 14'h0080;
  localparam logic [13:0] PCIN     = 14'h0040;
  localparam logic [13:0] YIN      = 14'h0020;
  localparam logic [13:0] ZIN      = 14'h0010;
  localparam logic [13:0] LOIN     = 14'h0008;
  localparam logic [13:0] HIIN     = 14'h0004;
  localparam logic [13:0] INCPC    = 14'h0002;
  localparam logic [13:0] READ     = 14'h0001;

  localparam logic [13:0] FT0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [13:0] FT1 = ZLOWOUT | PCIN;
  localparam logic [13:0] FT2 = READ | MDRIN;
  localparam logic [13:0] FT3 = MDROUT | IRIN;

  localparam logic [31:0] ALU_IR  = 32'h2A2B8000;  // SHL R4,R5,R7
  localparam logic [31:0] MUL_IR  = 32'h7B100000;  // MUL R6,R2
  localparam logic [31:0] ILL_IR  = 32'hF8000000;  // opcode 11111
  localparam logic [31:0] NOP_IR  = 32'hD0000000;  // opcode 11010
  localparam logic [31:0] HALT_IR = 32'hD8000000;  // opcode 11011

  localparam logic [4:0] OPZ = 5'b00000;
  localparam logic [4:0] SHL = 5'b00101;
  localparam logic [4:0] MUL = 5'b01111;

  logic [13:0] obsCtl;
  assign obsCtl = {PCout, Zlowout, ZHighout, MDRout, MARin, MDRin, IRin,
                   PCin, Yin, Zin, LOin, HIin, IncPC, Read};

  control_sequencer #(.RUN_START_PC(32'd0)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Run       (Run),
    .IR        (IR),
    .Mem_ready (Mem_ready),
    .PCout     (PCout),
    .Zlowout   (Zlowout),
    .ZHighout  (ZHighout),
    .MDRout    (MDRout),
    .Rout      (Rout),
    .Rin       (Rin),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .IRin      (IRin),
    .PCin      (PCin),
    .Yin       (Yin),
    .Zin       (Zin),
    .LOin      (LOin),
    .HIin      (HIin),
    .IncPC     (IncPC),
    .Read      (Read),
    .operation (operation),
    .Halted    (Halted),
    .Illegal   (Illegal)
  );

  // Free-running clock, 10 time units per period.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive all inputs at once; takes effect at the next rising edge.
  task automatic applyStimulus(input logic resetn, input logic run,
                               input logic memReady, input logic [31:0] ir);
    Resetn    = resetn;
    Run       = run;
    Mem_ready = memReady;
    IR        = ir;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Wait for the falling edge and compare every output with one step's values.
  task automatic expectCycle(input string tag, input logic [13:0] ctl,
                             input logic [15:0] rout, input logic [15:0] rin,
                             input logic [4:0] op, input logic halted,
                             input logic illegal);
    @(negedge Clock);
    cycleNum++;
    checkOutput($sformatf("%s@%0d.ctl", tag, cycleNum), {2'b00, obsCtl}, {2'b00, ctl});
    checkOutput($sformatf("%s@%0d.Rout", tag, cycleNum), Rout, rout);
    checkOutput($sformatf("%s@%0d.Rin", tag, cycleNum), Rin, rin);
    checkOutput($sformatf("%s@%0d.operation", tag, cycleNum), {11'd0, operation}, {11'd0, op});
    checkOutput($sformatf("%s@%0d.Halted", tag, cycleNum), {15'd0, Halted}, {15'd0, halted});
    checkOutput($sformatf("%s@%0d.Illegal", tag, cycleNum), {15'd0, Illegal}, {15'd0, illegal});
  endtask

  // At most one bus source may drive in any cycle.
  always @(negedge Clock) begin
    if (busCheckOn) begin
      int busSources;
      busSources = int'(PCout) + int'(Zlowout) + int'(ZHighout) +
                   int'(MDRout) + $countones(Rout);
      checks++;
      assert (busSources <= 1) else begin
        errors++;
        $error("[TB] FAIL busSources observed=%0d expected<=1", busSources);
      end
    end
  end

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    cycleNum   = 0;
    busCheckOn = 1'b0;

    // Reset, then one idle cycle with Run low.
    applyStimulus(1'b0, 1'b0, 1'b1, ALU_IR);
    repeat (2) @(posedge Clock);
    expectCycle("reset", '0, '0, '0, OPZ, 1'b0, 1'b0);
    busCheckOn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, ALU_IR);
    expectCycle("idleNoRun", '0, '0, '0, OPZ, 1'b0, 1'b0);

    // SHL R4,R5,R7 with memory ready: T0..T6 then the next fetch.
    applyStimulus(1'b1, 1'b1, 1'b1, ALU_IR);
    expectCycle("alu.T0", FT0, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("alu.T1", FT1, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("alu.T2", FT2, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("alu.T3", FT3, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("alu.T4", YIN, 16'h0020, '0, OPZ, 1'b0, 1'b0);
    expectCycle("alu.T5", ZIN, 16'h0080, '0, SHL, 1'b0, 1'b0);
    expectCycle("alu.T6", ZLOWOUT, '0, 16'h0010, SHL, 1'b0, 1'b0);
    expectCycle("alu.next", FT0, '0, '0, SHL, 1'b0, 1'b0);

    // MUL R6,R2; Run dropped mid-instruction must not cut it short.
    applyStimulus(1'b1, 1'b1, 1'b1, MUL_IR);
    expectCycle("mul.T1", FT1, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("mul.T2", FT2, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("mul.T3", FT3, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("mul.T4", YIN, 16'h0040, '0, SHL, 1'b0, 1'b0);
    expectCycle("mul.T5", ZIN, 16'h0004, '0, MUL, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, MUL_IR);
    expectCycle("mul.T6", ZLOWOUT | LOIN, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("mul.T7", ZHIGHOUT | HIIN, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("mul.idle", '0, '0, '0, MUL, 1'b0, 1'b0);

    // ALU with memory not ready for three T2 edges: ten cycles in total.
    applyStimulus(1'b1, 1'b1, 1'b0, ALU_IR);
    expectCycle("wait.T0", FT0, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("wait.T1", FT1, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("wait.T2a", FT2, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("wait.T2b", FT2, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("wait.T2c", FT2, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("wait.T2d", FT2, '0, '0, MUL, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, ALU_IR);
    expectCycle("wait.T3", FT3, '0, '0, MUL, 1'b0, 1'b0);
    expectCycle("wait.T4", YIN, 16'h0020, '0, MUL, 1'b0, 1'b0);
    expectCycle("wait.T5", ZIN, 16'h0080, '0, SHL, 1'b0, 1'b0);
    expectCycle("wait.T6", ZLOWOUT, '0, 16'h0010, SHL, 1'b0, 1'b0);
    expectCycle("wait.next", FT0, '0, '0, SHL, 1'b0, 1'b0);

    // Illegal opcode: one-cycle pulse alongside the next fetch, no Rin.
    applyStimulus(1'b1, 1'b1, 1'b1, ILL_IR);
    expectCycle("ill.T1", FT1, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("ill.T2", FT2, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("ill.T3", FT3, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("ill.next", FT0, '0, '0, SHL, 1'b0, 1'b1);

    // NOP: four cycles and no pulse.
    applyStimulus(1'b1, 1'b1, 1'b1, NOP_IR);
    expectCycle("nop.T1", FT1, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("nop.T2", FT2, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("nop.T3", FT3, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("nop.next", FT0, '0, '0, SHL, 1'b0, 1'b0);

    // HALT: sets Halted and stays idle even with Run high.
    applyStimulus(1'b1, 1'b1, 1'b1, HALT_IR);
    expectCycle("halt.T1", FT1, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("halt.T2", FT2, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("halt.T3", FT3, '0, '0, SHL, 1'b0, 1'b0);
    expectCycle("halt.idle0", '0, '0, '0, SHL, 1'b1, 1'b0);
    expectCycle("halt.idle1", '0, '0, '0, SHL, 1'b1, 1'b0);
    expectCycle("halt.idle2", '0, '0, '0, SHL, 1'b1, 1'b0);

    // Reset clears Halted and operation.
    applyStimulus(1'b0, 1'b1, 1'b1, ALU_IR);
    expectCycle("halt.reset", '0, '0, '0, OPZ, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, ALU_IR);
    expectCycle("post.idle", '0, '0, '0, OPZ, 1'b0, 1'b0);

    // Reset during T5 of an ALU instruction.
    applyStimulus(1'b1, 1'b1, 1'b1, ALU_IR);
    expectCycle("rst.T0", FT0, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("rst.T1", FT1, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("rst.T2", FT2, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("rst.T3", FT3, '0, '0, OPZ, 1'b0, 1'b0);
    expectCycle("rst.T4", YIN, 16'h0020, '0, OPZ, 1'b0, 1'b0);
    expectCycle("rst.T5", ZIN, 16'h0080, '0, SHL, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, ALU_IR);
    expectCycle("rst.cleared", '0, '0, '0, OPZ, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, ALU_IR);
    expectCycle("rst.restartT0", FT0, '0, '0, OPZ, 1'b0, 1'b0);

    busCheckOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
